// File: rtl/duckhunt_pkg.sv
// Shared types and widths for the duck-hunt game sequencer.
// Contents: state enum (state_t), counter/score widths, round limits.
package duckhunt_pkg;

    localparam int unsigned STATE_W        = 3;
    localparam int unsigned SCORE_W        = 16;
    localparam int unsigned ROUND_W        = 7;
    localparam int unsigned SHOTS_W        = 2;
    localparam int unsigned IDX_W          = 4;
    localparam int unsigned HITS_W         = 4;
    localparam int unsigned MAX_ROUND      = 99;
    localparam int unsigned ROUND_MULT_CAP = 10;

    typedef enum logic [STATE_W-1:0] {
        S_TITLE  = 3'd0,
        S_INTRO  = 3'd1,
        S_FLY    = 3'd2,
        S_FALL   = 3'd3,
        S_ESCAPE = 3'd4,
        S_RESULT = 3'd5,
        S_OVER   = 3'd6
    } state_t;

endpackage

// File: rtl/game_flow_ctrl_if.sv
// Player-input / game-status bundle between the sequencer and its neighbours.
// Inputs to the sequencer: start, mouse_left, duck_hit.
// Outputs from the sequencer: state, duck_launch, duck_active, duck_falling,
// endgame, shots_left, duck_idx, round_hits, round_num, score.
// slave modport = sequencer side, master modport = title screen / renderer side.
interface game_flow_ctrl_if;
    import duckhunt_pkg::*;

    logic                 start;
    logic                 mouse_left;
    logic                 duck_hit;
    state_t               state;
    logic                 duck_launch;
    logic                 duck_active;
    logic                 duck_falling;
    logic                 endgame;
    logic [SHOTS_W-1:0]   shots_left;
    logic [IDX_W-1:0]     duck_idx;
    logic [HITS_W-1:0]    round_hits;
    logic [ROUND_W-1:0]   round_num;
    logic [SCORE_W-1:0]   score;

    modport master (
        output start, mouse_left, duck_hit,
        input  state, duck_launch, duck_active, duck_falling, endgame,
        input  shots_left, duck_idx, round_hits, round_num, score
    );

    modport slave (
        input  start, mouse_left, duck_hit,
        output state, duck_launch, duck_active, duck_falling, endgame,
        output shots_left, duck_idx, round_hits, round_num, score
    );

endinterface

// File: rtl/frame_timer.sv
// Loadable frame down-counter shared by all timed game states.
// Ports: frame_clk, Reset (async, active-high), load, load_val,
// expired_c (combinational: count has reached zero).
module frame_timer #(
    parameter int unsigned WIDTH = 9
) (
    input  logic             frame_clk,
    input  logic             Reset,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic             expired_c
);

    logic [WIDTH-1:0] count_q;

    // Counter holds at zero until the next load
    always_ff @(posedge frame_clk or posedge Reset) begin
        if (Reset) begin
            count_q <= '0;
        end else if (load) begin
            count_q <= load_val;
        end else if (count_q != '0) begin
            count_q <= count_q - WIDTH'(1);
        end
    end

    assign expired_c = (count_q == '0);

endmodule

// File: rtl/game_flow_ctrl.sv
// Per-frame game sequencer: title, round intro, duck flight, fall/escape,
// round result and game over; keeps shots, hits, round number and score.
// Ports: frame_clk, Reset (async, active-high), bus (game_flow_ctrl_if.slave).
// Build option: SCORE_BCD_EN -- score kept as 4 BCD digits, saturating at 9999;
// otherwise binary, saturating at 65535.
module game_flow_ctrl
    import duckhunt_pkg::*;
#(
    parameter int unsigned SHOTS_PER_DUCK  = 3,
    parameter int unsigned DUCKS_PER_ROUND = 10,
    parameter int unsigned MIN_HITS        = 6,
    parameter int unsigned INTRO_FRAMES    = 120,
    parameter int unsigned FLY_FRAMES      = 300,
    parameter int unsigned FALL_FRAMES     = 60,
    parameter int unsigned RESULT_FRAMES   = 120,
    parameter int unsigned OVER_FRAMES     = 180,
    parameter int unsigned POINTS_PER_HIT  = 100
) (
    input  logic            frame_clk,
    input  logic            Reset,
    game_flow_ctrl_if.slave bus
);

    localparam int unsigned MAX_A      = (INTRO_FRAMES > FLY_FRAMES) ? INTRO_FRAMES : FLY_FRAMES;
    localparam int unsigned MAX_B      = (FALL_FRAMES > RESULT_FRAMES) ? FALL_FRAMES : RESULT_FRAMES;
    localparam int unsigned MAX_C      = (MAX_A > MAX_B) ? MAX_A : MAX_B;
    localparam int unsigned MAX_FRAMES = (MAX_C > OVER_FRAMES) ? MAX_C : OVER_FRAMES;
    localparam int unsigned TIMER_W    = $clog2(MAX_FRAMES + 1);

    state_t               state_q, state_n;
    logic [SHOTS_W-1:0]   shots_q, shots_n;
    logic [IDX_W-1:0]     idx_q, idx_n;
    logic [HITS_W-1:0]    hits_q, hits_n;
    logic [ROUND_W-1:0]   round_q, round_n;
    logic [SCORE_W-1:0]   score_q, score_n;
    logic                 mouse_q;
    logic                 launch_q, launch_n;
    logic                 active_q, active_n;
    logic                 falling_q, falling_n;
    logic                 endgame_q, endgame_n;

    logic                 click_c;
    logic                 expired_c;
    logic                 load_c;
    logic [TIMER_W-1:0]   load_val_c;
    logic [ROUND_W-1:0]   mult_c;
    logic [SCORE_W-1:0]   points_c;
    logic [SCORE_W-1:0]   score_add_c;
    logic [IDX_W-1:0]     idx_inc_c;

`ifdef SCORE_BCD_EN
    logic [19:0]          pts_bcd_c;
    logic [SCORE_W:0]     bcd_sum_c;

    // Double-dabble conversion of the binary point value to 5 BCD digits
    function automatic logic [19:0] bin_to_bcd(input logic [15:0] bin);
        logic [35:0] sh;
        sh = {20'd0, bin};
        for (int i = 0; i < 16; i++) begin
            for (int d = 0; d < 5; d++) begin
                if (sh[16 + 4*d +: 4] >= 4'd5) begin
                    sh[16 + 4*d +: 4] = sh[16 + 4*d +: 4] + 4'd3;
                end
            end
            sh = sh << 1;
        end
        return sh[35:16];
    endfunction

    // Ripple the add through the four digits, least significant first; bit 16 is carry out
    function automatic logic [16:0] bcd_add(input logic [15:0] a, input logic [15:0] b);
        logic [16:0] r;
        logic [4:0]  s;
        logic        c;
        r = '0;
        c = 1'b0;
        for (int d = 0; d < 4; d++) begin
            s = 5'(a[4*d +: 4]) + 5'(b[4*d +: 4]) + 5'(c);
            if (s > 5'd9) begin
                s = s + 5'd6;
                c = 1'b1;
            end else begin
                c = 1'b0;
            end
            r[4*d +: 4] = s[3:0];
        end
        r[16] = c;
        return r;
    endfunction
`else
    logic [SCORE_W:0]     sum_c;
`endif

    assign click_c = bus.mouse_left & ~mouse_q;

    // Score candidate for a hit this frame: base points times capped round number
    always_comb begin
        mult_c   = (round_q > ROUND_W'(ROUND_MULT_CAP)) ? ROUND_W'(ROUND_MULT_CAP) : round_q;
        points_c = SCORE_W'(POINTS_PER_HIT * 32'(mult_c));
`ifdef SCORE_BCD_EN
        pts_bcd_c = bin_to_bcd(points_c);
        bcd_sum_c = bcd_add(score_q, pts_bcd_c[15:0]);
        if ((pts_bcd_c[19:16] != 4'd0) || bcd_sum_c[SCORE_W]) begin
            score_add_c = 16'h9999;
        end else begin
            score_add_c = bcd_sum_c[SCORE_W-1:0];
        end
`else
        sum_c       = {1'b0, score_q} + {1'b0, points_c};
        score_add_c = sum_c[SCORE_W] ? '1 : sum_c[SCORE_W-1:0];
`endif
    end

    // Next-state, counter updates and registered-output decode
    always_comb begin
        state_n   = state_q;
        shots_n   = shots_q;
        idx_n     = idx_q;
        hits_n    = hits_q;
        round_n   = round_q;
        score_n   = score_q;
        idx_inc_c = idx_q + IDX_W'(1);

        case (state_q)
            S_TITLE: begin
                score_n = '0;
                round_n = ROUND_W'(1);
                hits_n  = '0;
                idx_n   = '0;
                if (bus.start) begin
                    state_n = S_INTRO;
                end
            end
            S_INTRO: begin
                if (expired_c) begin
                    state_n = S_FLY;
                    shots_n = SHOTS_W'(SHOTS_PER_DUCK);
                end
            end
            S_FLY: begin
                // A click in the expiry frame wins over the timeout
                if (click_c && bus.duck_hit) begin
                    shots_n = shots_q - SHOTS_W'(1);
                    hits_n  = hits_q + HITS_W'(1);
                    score_n = score_add_c;
                    state_n = S_FALL;
                end else if (click_c) begin
                    shots_n = shots_q - SHOTS_W'(1);
                    if (shots_q == SHOTS_W'(1)) begin
                        state_n = S_ESCAPE;
                    end
                end else if (expired_c) begin
                    state_n = S_ESCAPE;
                end
            end
            S_FALL, S_ESCAPE: begin
                if (expired_c) begin
                    idx_n = idx_inc_c;
                    if (idx_inc_c == IDX_W'(DUCKS_PER_ROUND)) begin
                        state_n = S_RESULT;
                    end else begin
                        state_n = S_FLY;
                        shots_n = SHOTS_W'(SHOTS_PER_DUCK);
                    end
                end
            end
            S_RESULT: begin
                if (expired_c) begin
                    if (hits_q >= HITS_W'(MIN_HITS)) begin
                        round_n = (round_q >= ROUND_W'(MAX_ROUND)) ? round_q : round_q + ROUND_W'(1);
                        hits_n  = '0;
                        idx_n   = '0;
                        state_n = S_INTRO;
                    end else begin
                        state_n = S_OVER;
                    end
                end
            end
            S_OVER: begin
                if (expired_c) begin
                    state_n = S_TITLE;
                end
            end
            default: begin
                state_n = S_TITLE;
            end
        endcase

        launch_n  = (state_n == S_FLY) && (state_q != S_FLY);
        active_n  = (state_n == S_FLY);
        falling_n = (state_n == S_FALL);
        endgame_n = (state_n == S_OVER);
    end

    // Timer restarts on every state change with the new state's duration
    always_comb begin
        load_c     = (state_n != state_q);
        load_val_c = '0;
        case (state_n)
            S_INTRO:          load_val_c = TIMER_W'(INTRO_FRAMES - 1);
            S_FLY:            load_val_c = TIMER_W'(FLY_FRAMES - 1);
            S_FALL, S_ESCAPE: load_val_c = TIMER_W'(FALL_FRAMES - 1);
            S_RESULT:         load_val_c = TIMER_W'(RESULT_FRAMES - 1);
            S_OVER:           load_val_c = TIMER_W'(OVER_FRAMES - 1);
            default:          load_val_c = '0;
        endcase
    end

    frame_timer #(
        .WIDTH (TIMER_W)
    ) u_frame_timer (
        .frame_clk (frame_clk),
        .Reset     (Reset),
        .load      (load_c),
        .load_val  (load_val_c),
        .expired_c (expired_c)
    );

    // State and counter registers
    always_ff @(posedge frame_clk or posedge Reset) begin
        if (Reset) begin
            state_q   <= S_TITLE;
            shots_q   <= SHOTS_W'(SHOTS_PER_DUCK);
            idx_q     <= '0;
            hits_q    <= '0;
            round_q   <= ROUND_W'(1);
            score_q   <= '0;
            mouse_q   <= 1'b0;
            launch_q  <= 1'b0;
            active_q  <= 1'b0;
            falling_q <= 1'b0;
            endgame_q <= 1'b0;
        end else begin
            state_q   <= state_n;
            shots_q   <= shots_n;
            idx_q     <= idx_n;
            hits_q    <= hits_n;
            round_q   <= round_n;
            score_q   <= score_n;
            mouse_q   <= bus.mouse_left;
            launch_q  <= launch_n;
            active_q  <= active_n;
            falling_q <= falling_n;
            endgame_q <= endgame_n;
        end
    end

    assign bus.state        = state_q;
    assign bus.duck_launch  = launch_q;
    assign bus.duck_active  = active_q;
    assign bus.duck_falling = falling_q;
    assign bus.endgame      = endgame_q;
    assign bus.shots_left   = shots_q;
    assign bus.duck_idx     = idx_q;
    assign bus.round_hits   = hits_q;
    assign bus.round_num    = round_q;
    assign bus.score        = score_q;

endmodule
